gem_ext_fifo_rx: RTL and testbench

Receive-side companion of the GEM external FIFO transmitter. Accepts the ZynqMP GEM RX external-FIFO write interface and emits frames as an 8-bit AXI-Stream master. A small internal buffer absorbs the short stalls the GEM cannot see, because the GEM side has no backpressure. Frames are marked bad via `tuser` on the `tlast` beat so that a downstream frame FIFO can drop them.

---
 rtl/gem_ext_fifo_pkg.sv | 32 +++
 rtl/gem_ext_fifo_rx_if.sv | 12 +
 rtl/gem_ext_fifo_rx_buf.sv | 85 ++++++++
 rtl/gem_ext_fifo_rx.sv | 166 ++++++++++++++++
 tb/tb_gem_ext_fifo_rx.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gem_ext_fifo_pkg.sv
// Shared types for the GEM external-FIFO receive path: FSM states,
// buffer entry layout and the terminator entry used to close a frame.
package gem_ext_fifo_pkg;

  localparam int GEM_RX_STATUS_WIDTH = 45;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_DROP
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } rx_entry_t;

  // Closes an abandoned frame; downstream sees a bad, empty tail byte.
  localparam rx_entry_t TERM_ENTRY = '{data: 8'h00, last: 1'b1, user: 1'b1};

  function automatic rx_entry_t make_entry(input logic [7:0] data,
                                           input logic       last,
                                           input logic       user);
    rx_entry_t e;
    e.data = data;
    e.last = last;
    e.user = user;
    return e;
  endfunction

endpackage

// File: rtl/gem_ext_fifo_rx_if.sv
// 8-bit AXI-Stream link carrying received frames; tuser flags a bad frame
// on the tlast beat.
interface gem_ext_fifo_rx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/gem_ext_fifo_rx_buf.sv
// First-word-fall-through buffer: an output register fed either directly
// from the write port (bypass) or from the backing array.
module gem_ext_fifo_rx_buf
  import gem_ext_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  rx_entry_t                  push_entry,
  input  logic                       ready,
  output rx_entry_t                  out_entry,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);

  rx_entry_t          mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     mem_count_reg;
  rx_entry_t          out_reg;
  logic               out_valid_reg;

  logic pop;
  logic load_out;
  logic accept;
  logic mem_empty;
  logic bypass;
  logic mem_wr;
  logic mem_rd;

  assign pop       = out_valid_reg & ready;
  assign load_out  = ~out_valid_reg | pop;
  assign accept    = push & ((level != (PTR_W + 1)'(DEPTH)) | pop);
  assign mem_empty = (mem_count_reg == '0);
  // With nothing queued behind it, a new entry goes straight to the output.
  assign bypass    = accept & load_out & mem_empty;
  assign mem_wr    = accept & ~bypass;
  assign mem_rd    = load_out & ~mem_empty;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      mem_count_reg <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (mem_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (mem_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({mem_wr, mem_rd})
        2'b10:   mem_count_reg <= mem_count_reg + (PTR_W + 1)'(1);
        2'b01:   mem_count_reg <= mem_count_reg - (PTR_W + 1)'(1);
        default: mem_count_reg <= mem_count_reg;
      endcase
      if (mem_rd) begin
        out_reg       <= mem[rd_ptr_reg];
        out_valid_reg <= 1'b1;
      end else if (bypass) begin
        out_reg       <= push_entry;
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_entry = out_reg;
  assign out_valid = out_valid_reg;
  assign level     = mem_count_reg + {{PTR_W{1'b0}}, out_valid_reg};

endmodule

// File: rtl/gem_ext_fifo_rx.sv
// GEM RX external-FIFO write port to 8-bit AXI-Stream, with frame-level
// error marking, overflow signalling and saturating frame statistics.
module gem_ext_fifo_rx
  import gem_ext_fifo_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STATUS_WIDTH = GEM_RX_STATUS_WIDTH,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              gem_rx_data,
  input  logic                    gem_rx_wr,
  input  logic                    gem_rx_sop,
  input  logic                    gem_rx_eop,
  input  logic                    gem_rx_err,
  input  logic [STATUS_WIDTH-1:0] gem_rx_status,
  input  logic                    gem_rx_flush,
  output logic                    gem_rx_overflow,
  gem_ext_fifo_rx_if.master       m_axis,
  output logic [STATUS_WIDTH-1:0] rx_status,
  output logic                    rx_status_valid,
  output logic [CNT_WIDTH-1:0]    cnt_good,
  output logic [CNT_WIDTH-1:0]    cnt_bad,
  output logic [CNT_WIDTH-1:0]    cnt_drop
);

  localparam int LEVEL_W = $clog2(DEPTH) + 1;

  rx_state_t               state_reg;
  rx_state_t               state_next;
  logic                    err_seen_reg;
  logic                    overflow_reg;
  logic [STATUS_WIDTH-1:0] rx_status_reg;
  logic                    rx_status_valid_reg;

  logic [LEVEL_W-1:0] level;
  logic               room;
  logic               push;
  rx_entry_t          push_entry;
  rx_entry_t          out_entry;
  logic               out_valid;
  logic               ovf_hit;
  logic               drop_hit;
  logic               status_hit;
  logic [2:0]         cnt_inc;

  // Ordinary bytes may fill up to DEPTH-1; the last slot is kept for a closer.
  assign room = (level < LEVEL_W'(DEPTH - 1));

  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    state_next = state_reg;
    ovf_hit    = 1'b0;
    drop_hit   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (gem_rx_wr && gem_rx_sop) begin
          if (room) begin
            push       = 1'b1;
            push_entry = make_entry(gem_rx_data, gem_rx_eop, gem_rx_eop & gem_rx_err);
            if (!gem_rx_eop) state_next = ST_FRAME;
          end else begin
            ovf_hit  = 1'b1;
            drop_hit = 1'b1;
            if (!gem_rx_eop) state_next = ST_DROP;
          end
        end
      end
      ST_FRAME: begin
        if (gem_rx_flush) begin
          push       = 1'b1;
          push_entry = TERM_ENTRY;
          state_next = ST_IDLE;
        end else if (gem_rx_wr) begin
          push = 1'b1;
          if (gem_rx_sop) begin
            // Missing eop: this byte closes the old frame as bad.
            push_entry = make_entry(gem_rx_data, 1'b1, 1'b1);
            state_next = gem_rx_eop ? ST_IDLE : ST_DROP;
          end else if (room) begin
            push_entry = make_entry(gem_rx_data, gem_rx_eop,
                                    gem_rx_eop & (err_seen_reg | gem_rx_err));
            if (gem_rx_eop) state_next = ST_IDLE;
          end else begin
            push_entry = make_entry(gem_rx_data, 1'b1, 1'b1);
            ovf_hit    = 1'b1;
            state_next = gem_rx_eop ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (gem_rx_flush || (gem_rx_wr && gem_rx_eop)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign status_hit = gem_rx_wr & gem_rx_eop & (state_reg != ST_DROP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= ST_IDLE;
      err_seen_reg        <= 1'b0;
      overflow_reg        <= 1'b0;
      rx_status_reg       <= '0;
      rx_status_valid_reg <= 1'b0;
    end else begin
      state_reg           <= state_next;
      overflow_reg        <= ovf_hit;
      rx_status_valid_reg <= status_hit;
      if (status_hit) rx_status_reg <= gem_rx_status;
      if (state_next == ST_IDLE) begin
        err_seen_reg <= 1'b0;
      end else if (push && !push_entry.last && gem_rx_err) begin
        err_seen_reg <= 1'b1;
      end
    end
  end

  gem_ext_fifo_rx_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .ready      (m_axis.tready),
    .out_entry  (out_entry),
    .out_valid  (out_valid),
    .level      (level)
  );

  // Counter index: 0 = good frames, 1 = bad frames, 2 = dropped frames.
  assign cnt_inc = {drop_hit, push & push_entry.last & push_entry.user,
                    push & push_entry.last & ~push_entry.user};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= '0;
        end else if (cnt_inc[gi] && (count_reg != '1)) begin
          count_reg <= count_reg + CNT_WIDTH'(1);
        end
      end
    end
  endgenerate

  assign cnt_good = g_cnt[0].count_reg;
  assign cnt_bad  = g_cnt[1].count_reg;
  assign cnt_drop = g_cnt[2].count_reg;

  assign m_axis.tdata  = out_entry.data;
  assign m_axis.tlast  = out_entry.last;
  assign m_axis.tuser  = out_entry.user;
  assign m_axis.tvalid = out_valid;

  assign gem_rx_overflow = overflow_reg;
  assign rx_status       = rx_status_reg;
  assign rx_status_valid = rx_status_valid_reg;

endmodule

// File: tb/tb_gem_ext_fifo_rx.sv
// Directed bench for gem_ext_fifo_rx: frames in on the GEM port, beats
// collected from the AXI-Stream side and compared against hand-built values.
module tb_gem_ext_fifo_rx;
  import gem_ext_fifo_pkg::*;

  localparam int SW = 45;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    gem_rx_data;
  logic          gem_rx_wr, gem_rx_sop, gem_rx_eop, gem_rx_err, gem_rx_flush;
  logic [SW-1:0] gem_rx_status;
  logic          gem_rx_overflow;
  logic [SW-1:0] rx_status;
  logic          rx_status_valid;
  logic [CW-1:0] cnt_good, cnt_bad, cnt_drop;

  gem_ext_fifo_rx_if m_axis();

  gem_ext_fifo_rx #(
    .DEPTH        (16),
    .STATUS_WIDTH (SW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .gem_rx_data     (gem_rx_data),
    .gem_rx_wr       (gem_rx_wr),
    .gem_rx_sop      (gem_rx_sop),
    .gem_rx_eop      (gem_rx_eop),
    .gem_rx_err      (gem_rx_err),
    .gem_rx_status   (gem_rx_status),
    .gem_rx_flush    (gem_rx_flush),
    .gem_rx_overflow (gem_rx_overflow),
    .m_axis          (m_axis),
    .rx_status       (rx_status),
    .rx_status_valid (rx_status_valid),
    .cnt_good        (cnt_good),
    .cnt_bad         (cnt_bad),
    .cnt_drop        (cnt_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t q[$];
  int    pass_cnt = 0;
  int    total_cnt = 0;
  int    ovf_cycles = 0;
  int    stv_cycles = 0;
  int    stab_errs = 0;
  logic  stall_prev = 1'b0;
  beat_t held = '0;

  // Collect handshaken beats and watch AXIS stability while stalled.
  always @(negedge clk) begin
    if (gem_rx_overflow === 1'b1) ovf_cycles++;
    if (rx_status_valid === 1'b1) stv_cycles++;
    if (stall_prev && ((m_axis.tvalid !== 1'b1) ||
        ({m_axis.tdata, m_axis.tlast, m_axis.tuser} !== held))) stab_errs++;
    stall_prev = (m_axis.tvalid === 1'b1) && (m_axis.tready === 1'b0);
    held = {m_axis.tdata, m_axis.tlast, m_axis.tuser};
    if (m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1)
      q.push_back({m_axis.tdata, m_axis.tlast, m_axis.tuser});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    chk({tag, "_avail"}, 64'(q.size() != 0), 64'd1);
    if (q.size() != 0) begin
      b = q.pop_front();
      chk(tag, {54'd0, b.d, b.l, b.u}, {54'd0, d, l, u});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic beat(input logic [7:0] d, input logic s, input logic e, input logic r);
    gem_rx_data = d;
    gem_rx_wr   = 1'b1;
    gem_rx_sop  = s;
    gem_rx_eop  = e;
    gem_rx_err  = r;
    tick();
    gem_rx_wr  = 1'b0;
    gem_rx_sop = 1'b0;
    gem_rx_eop = 1'b0;
    gem_rx_err = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input int err_at);
    for (int i = 1; i <= n; i++) beat(8'(int'(base) + i - 1), i == 1, i == n, i == err_at);
  endtask

  initial begin
    rst = 1'b1;
    gem_rx_data = '0; gem_rx_wr = 0; gem_rx_sop = 0; gem_rx_eop = 0;
    gem_rx_err = 0; gem_rx_flush = 0; gem_rx_status = '0;
    m_axis.tready = 1'b0;
    idle(3);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tuser", m_axis.tuser, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_ovf", gem_rx_overflow, 0);
    chk("rst_status", rx_status, 0);
    chk("rst_status_valid", rx_status_valid, 0);
    chk("rst_cnt_good", cnt_good, 0);
    chk("rst_cnt_bad", cnt_bad, 0);
    chk("rst_cnt_drop", cnt_drop, 0);
    rst = 1'b0;
    idle(1);

    // 64-byte good frame, tready always high
    m_axis.tready = 1'b1;
    gem_rx_status = 45'h123_4567_89AB;
    beat(8'd1, 1'b1, 1'b0, 1'b0);
    chk("t1_lat_valid", m_axis.tvalid, 1);
    chk("t1_lat_data", m_axis.tdata, 1);
    for (int i = 2; i <= 64; i++) beat(8'(i), 1'b0, i == 64, 1'b0);
    idle(4);
    chk("t1_count", q.size(), 64);
    for (int i = 1; i <= 64; i++) chk_beat("t1_beat", 8'(i), i == 64, 1'b0);
    chk("t1_cnt_good", cnt_good, 1);
    chk("t1_cnt_bad", cnt_bad, 0);
    chk("t1_status", rx_status, 45'h123_4567_89AB);
    chk("t1_status_pulses", stv_cycles, 1);
    chk("t1_ovf_none", ovf_cycles, 0);

    // 10-byte frame with err on byte 3
    gem_rx_status = 45'h0BAD_0000_02;
    send_frame(10, 8'h20, 3);
    idle(4);
    chk("t2_count", q.size(), 10);
    for (int i = 1; i <= 10; i++) chk_beat("t2_beat", 8'(32 + i - 1), i == 10, i == 10);
    chk("t2_cnt_bad", cnt_bad, 1);
    chk("t2_cnt_good", cnt_good, 1);

    // 40-byte frame into a stalled sink: 15 ordinary bytes + reserved closer
    m_axis.tready = 1'b0;
    gem_rx_status = 45'h1F_FFFF;
    send_frame(40, 8'h40, 0);
    idle(2);
    chk("t3_hold_valid", m_axis.tvalid, 1);
    chk("t3_hold_data", m_axis.tdata, 8'h40);
    chk("t3_ovf_pulse", ovf_cycles, 1);
    chk("t3_cnt_bad", cnt_bad, 2);
    chk("t3_status_kept", rx_status, 45'h0BAD_0000_02);
    chk("t3_status_pulses", stv_cycles, 2);
    m_axis.tready = 1'b1;
    idle(20);
    chk("t3_count", q.size(), 16);
    for (int i = 1; i <= 16; i++) chk_beat("t3_beat", 8'(64 + i - 1), i == 16, i == 16);
    send_frame(5, 8'h90, 0);
    idle(4);
    chk("t3b_count", q.size(), 5);
    for (int i = 1; i <= 5; i++) chk_beat("t3b_beat", 8'(144 + i - 1), i == 5, 1'b0);
    chk("t3b_cnt_good", cnt_good, 2);

    // 16 one-byte frames into a stalled sink: the 16th sop finds no room
    m_axis.tready = 1'b0;
    for (int i = 0; i < 16; i++) beat(8'(160 + i), 1'b1, 1'b1, 1'b0);
    idle(2);
    chk("t3c_ovf_pulse", ovf_cycles, 2);
    chk("t3c_cnt_drop", cnt_drop, 1);
    chk("t3c_cnt_good", cnt_good, 17);
    m_axis.tready = 1'b1;
    idle(20);
    chk("t3c_count", q.size(), 15);
    for (int i = 0; i < 15; i++) chk_beat("t3c_beat", 8'(160 + i), 1'b1, 1'b0);

    // flush after byte 5
    for (int i = 1; i <= 5; i++) beat(8'(176 + i - 1), i == 1, 1'b0, 1'b0);
    gem_rx_flush = 1'b1;
    tick();
    gem_rx_flush = 1'b0;
    idle(4);
    chk("t4_count", q.size(), 6);
    for (int i = 1; i <= 5; i++) chk_beat("t4_beat", 8'(176 + i - 1), 1'b0, 1'b0);
    chk_beat("t4_term", 8'h00, 1'b1, 1'b1);
    chk("t4_cnt_bad", cnt_bad, 3);
    send_frame(3, 8'hC0, 0);
    idle(4);
    chk("t4b_count", q.size(), 3);
    for (int i = 1; i <= 3; i++) chk_beat("t4b_beat", 8'(192 + i - 1), i == 3, 1'b0);
    chk("t4b_cnt_good", cnt_good, 18);

    // sop while a frame is open
    beat(8'hD0, 1'b1, 1'b0, 1'b0);
    beat(8'hD1, 1'b0, 1'b0, 1'b0);
    beat(8'hD2, 1'b1, 1'b0, 1'b0);
    beat(8'hD3, 1'b0, 1'b0, 1'b0);
    beat(8'hD4, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("t5_count", q.size(), 3);
    chk_beat("t5_beat0", 8'hD0, 1'b0, 1'b0);
    chk_beat("t5_beat1", 8'hD1, 1'b0, 1'b0);
    chk_beat("t5_close", 8'hD2, 1'b1, 1'b1);
    chk("t5_cnt_bad", cnt_bad, 4);
    send_frame(2, 8'hE0, 0);
    idle(4);
    chk("t5b_count", q.size(), 2);
    chk_beat("t5b_beat0", 8'hE0, 1'b0, 1'b0);
    chk_beat("t5b_beat1", 8'hE1, 1'b1, 1'b0);
    chk("t5b_cnt_good", cnt_good, 19);

    // back-to-back single-byte frames with random tready
    fork
      begin
        for (int i = 0; i < 24; i++) beat(8'(16 + i), 1'b1, 1'b1, 1'b0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          m_axis.tready = ($urandom_range(0, 7) != 0);
          tick();
        end
      end
    join
    m_axis.tready = 1'b1;
    idle(20);
    chk("t6_stable", stab_errs, 0);
    chk("t6_count", q.size(), 24);
    for (int i = 0; i < 24; i++) chk_beat("t6_beat", 8'(16 + i), 1'b1, 1'b0);
    chk("t6_cnt_good", cnt_good, 43);
    chk("t6_cnt_drop", cnt_drop, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
